fwd_source_pipe: RTL and testbench
==================================

# fwd_source_pipe

Producer side of the EXE-stage forwarding interface. Holds the EXE→MEM and MEM→WB pipeline registers and drives the register-file write port. Generates `dest_MEM`, `dest_WB`, `WB_EN_MEM` and `WB_EN_WB`, plus the matching forwarded data values `fwd_val_MEM` and `fwd_val_WB`, which the EXE forwarding selector consumes. Also owns the multi-cycle data-memory handshake and the pipeline freeze it causes.

## Interface
- `ADDR_W`, default 5: register-file address width.
- `DATA_W`, default 32: data word width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `WB_EN_EXE`, `MEM_R_EN_EXE`, `MEM_W_EN_EXE` in 1: control bits of the instruction leaving EXE.
- `dest_EXE` in ADDR_W: destination register of the instruction leaving EXE.
- `alu_res_EXE` in DATA_W: ALU result; also the memory address.
- `st_val_EXE` in DATA_W: store data, already forwarded.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write enable for that access.
- `mem_addr` out DATA_W, `mem_wdata` out DATA_W: access address and write data.
- `mem_ready` in 1: access complete; `mem_rdata` valid in the same cycle.
- `mem_rdata` in DATA_W: read data.
- `freeze` out 1: hold PC, IF, ID and EXE registers.
- `dest_MEM` out ADDR_W, `WB_EN_MEM` out 1, `fwd_val_MEM` out DATA_W: MEM-stage forwarding source.
- `dest_WB` out ADDR_W, `WB_EN_WB` out 1, `fwd_val_WB` out DATA_W: WB-stage forwarding source.
- `ld_in_MEM` out 1: MEM stage holds a load. The hazard unit must stall any dependent instruction.
- `rf_we` out 1, `rf_waddr` out ADDR_W, `rf_wdata` out DATA_W: register-file write port.

## Operation
- MEM register: {wb_en, r_en, w_en, dest, alu_res, st_val}. WB register: {wb_en, dest, data}.
- FSM has two states:
  - `RUN`: no pending access. Entered from reset.
  - `WAIT`: an access is pending.
- Transitions:
  - `RUN` → `WAIT` when the MEM register holds `r_en|w_en` and `mem_ready`=0.
  - `WAIT` → `RUN` on the cycle `mem_ready`=1.
- Memory port:
  - `mem_req` = MEM register `r_en|w_en`, driven combinationally from registered state.
  - `mem_we` = `w_en`; `mem_addr` = `alu_res`; `mem_wdata` = `st_val`.
- `freeze` = `mem_req & ~mem_ready`.
- When `freeze`=1:
  - The MEM register holds.
  - The WB register loads a bubble (`wb_en`=0). A completed instruction is therefore written exactly once.
- When `freeze`=0:
  - MEM loads the EXE inputs.
  - WB loads {MEM.wb_en, MEM.dest, r_en ? mem_rdata : alu_res}.
- Forwarding outputs:
  - `dest_MEM`/`WB_EN_MEM` come from the MEM register.
  - `dest_WB`/`WB_EN_WB` come from the WB register.
  - `fwd_val_MEM` = MEM `alu_res`; `fwd_val_WB` = WB data.
- `ld_in_MEM` = MEM `wb_en & r_en`.
- `WB_EN_MEM` = MEM `wb_en & ~r_en`. A load's address is never forwarded as data.
- Register-file port: `rf_we`/`rf_waddr`/`rf_wdata` = WB register fields.
- Destination 0 is forwarded like any other register; suppressing register-0 writes is the register file's job.

## Timing
- Reset, asynchronous: all stage register fields go to 0 and the FSM goes to `RUN`. Every output is therefore 0, including `mem_req` and `freeze`.
- Reset asserted mid-`WAIT` abandons the access; `mem_req` drops immediately.
- Latency:
  - Zero-wait access (`mem_ready`=1 in the first `mem_req` cycle): EXE→`rf_we` is 2 edges. The value is visible on `fwd_val_MEM` after 1 edge and on `fwd_val_WB` after 2 edges.
  - N-cycle access: adds N−1 frozen cycles.
- A non-memory instruction in MEM never asserts `mem_req` and never freezes.
- Back-to-back memory instructions each get their own request. The new request starts the cycle after the previous `mem_ready`.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `FWD_SRC_FORWARDING_EN`:
  - Defined: forwarding outputs behave as above.
  - Undefined: `WB_EN_MEM` and `WB_EN_WB` are tied to 0, so the EXE selector always picks register-file values. `ld_in_MEM`, the register-file port and the memory behaviour are unchanged.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release → all outputs 0; first edge loads EXE values into MEM.
- ALU op, `WB_EN_EXE`=1, dest 5, result 0x1234 → edge 1: `dest_MEM`=5, `WB_EN_MEM`=1, `fwd_val_MEM`=0x1234; edge 2: `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234.
- Load, dest 7, addr 0x40, `mem_ready` low for 3 cycles then high with `mem_rdata`=0xBEEF → `ld_in_MEM`=1, `WB_EN_MEM`=0, `freeze`=1 for 3 cycles; `WB_EN_WB`=0 during the wait; then exactly one `rf_we` pulse with 0xBEEF to register 7.
- Store, addr 0x80, data 0xAA, zero-wait → `mem_req`=`mem_we`=1 for one cycle, `freeze` never 1, `rf_we` stays 0.
- Reset asserted in the 2nd `WAIT` cycle → `mem_req`, `freeze` and `rf_we` go to 0 immediately, with no write-back after release.
- Build without `FWD_SRC_FORWARDING_EN`, repeat the ALU test → `WB_EN_MEM`=`WB_EN_WB`=0 throughout, and the register-file write is identical.

Source files
------------

// File: rtl/fwd_source_pipe.sv
// fwd_source_pipe: EXE->MEM and MEM->WB pipeline registers, data-memory
// handshake with pipeline freeze, forwarding sources and RF write port.
// Optional feature macro: FWD_SRC_FORWARDING_EN (when undefined, WB_EN_MEM
// and WB_EN_WB are tied low so the EXE selector always uses RF values).
module fwd_source_pipe #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_EN_EXE,
   input  logic              MEM_R_EN_EXE,
   input  logic              MEM_W_EN_EXE,
   input  logic [ADDR_W-1:0] dest_EXE,
   input  logic [DATA_W-1:0] alu_res_EXE,
   input  logic [DATA_W-1:0] st_val_EXE,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              freeze,
   output logic [ADDR_W-1:0] dest_MEM,
   output logic              WB_EN_MEM,
   output logic [DATA_W-1:0] fwd_val_MEM,
   output logic [ADDR_W-1:0] dest_WB,
   output logic              WB_EN_WB,
   output logic [DATA_W-1:0] fwd_val_WB,
   output logic              ld_in_MEM,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

   state_t              state;

   // MEM stage register
   logic                m_wb_en, m_r_en, m_w_en;
   logic [ADDR_W-1:0]   m_dest;
   logic [DATA_W-1:0]   m_alu, m_st;

   // WB stage register
   logic                w_wb_en;
   logic [ADDR_W-1:0]   w_dest;
   logic [DATA_W-1:0]   w_data;

   // Memory port and freeze come straight from the registered MEM fields
   always_comb begin
      mem_req   = m_r_en | m_w_en;
      mem_we    = m_w_en;
      mem_addr  = m_alu;
      mem_wdata = m_st;
      freeze    = mem_req & ~mem_ready;
   end

   // Access tracking: WAIT while a request is outstanding, back to RUN on ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (mem_req && !mem_ready) state <= WAIT;
            WAIT:    if (mem_ready)             state <= RUN;
            default:                            state <= RUN;
         endcase
      end
   end

   // MEM register holds during a freeze; otherwise takes the EXE instruction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_wb_en <= 1'b0;
         m_r_en  <= 1'b0;
         m_w_en  <= 1'b0;
         m_dest  <= '0;
         m_alu   <= '0;
         m_st    <= '0;
      end else if (!freeze) begin
         m_wb_en <= WB_EN_EXE;
         m_r_en  <= MEM_R_EN_EXE;
         m_w_en  <= MEM_W_EN_EXE;
         m_dest  <= dest_EXE;
         m_alu   <= alu_res_EXE;
         m_st    <= st_val_EXE;
      end
   end

   // WB register takes a bubble while frozen so a stalled load writes once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_wb_en <= 1'b0;
         w_dest  <= '0;
         w_data  <= '0;
      end else if (freeze) begin
         w_wb_en <= 1'b0;
      end else begin
         w_wb_en <= m_wb_en;
         w_dest  <= m_dest;
         w_data  <= m_r_en ? mem_rdata : m_alu;
      end
   end

   // Forwarding sources and register-file write port
   always_comb begin
      dest_MEM    = m_dest;
      fwd_val_MEM = m_alu;
      dest_WB     = w_dest;
      fwd_val_WB  = w_data;
      ld_in_MEM   = m_wb_en & m_r_en;
      rf_we       = w_wb_en;
      rf_waddr    = w_dest;
      rf_wdata    = w_data;
`ifdef FWD_SRC_FORWARDING_EN
      // a load's MEM-stage value is its address, never forwardable data
      WB_EN_MEM   = m_wb_en & ~m_r_en;
      WB_EN_WB    = w_wb_en;
`else
      WB_EN_MEM   = 1'b0;
      WB_EN_WB    = 1'b0;
`endif
   end

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Self-checking bench for fwd_source_pipe: directed scenarios plus random
// traffic against an instruction-level reference model.
module tb_fwd_source_pipe;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef FWD_SRC_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE;
   logic [AW-1:0] dest_EXE;
   logic [DW-1:0] alu_res_EXE, st_val_EXE;
   logic          mem_req, mem_we;
   logic [DW-1:0] mem_addr, mem_wdata;
   logic          mem_ready;
   logic [DW-1:0] mem_rdata;
   logic          freeze;
   logic [AW-1:0] dest_MEM, dest_WB, rf_waddr;
   logic          WB_EN_MEM, WB_EN_WB, ld_in_MEM, rf_we;
   logic [DW-1:0] fwd_val_MEM, fwd_val_WB, rf_wdata;

   int checks = 0;
   int errors = 0;

   fwd_source_pipe #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
      .dest_EXE(dest_EXE), .alu_res_EXE(alu_res_EXE), .st_val_EXE(st_val_EXE),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .freeze(freeze),
      .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .fwd_val_MEM(fwd_val_MEM),
      .dest_WB(dest_WB), .WB_EN_WB(WB_EN_WB), .fwd_val_WB(fwd_val_WB),
      .ld_in_MEM(ld_in_MEM), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   // Reference model: the instruction sitting in MEM and the one in WB
   typedef struct {
      bit            wb, rd, wr;
      logic [AW-1:0] dest;
      logic [DW-1:0] alu, st;
   } mem_ins_t;
   typedef struct {
      bit            wb;
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } wb_ins_t;

   mem_ins_t mi;
   wb_ins_t  wi;
   int       wr_cnt;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mi.wb = 0; mi.rd = 0; mi.wr = 0; mi.dest = '0; mi.alu = '0; mi.st = '0;
      wi.wb = 0; wi.dest = '0; wi.data = '0;
   endtask

   // One clock edge at instruction level: a pending access that is not ready
   // keeps its instruction in MEM and sends nothing onward.
   task automatic model_edge();
      bit stalled;
      stalled = (mi.rd || mi.wr) && !mem_ready;
      if (stalled) begin
         wi.wb = 0;
      end else begin
         wi.wb   = mi.wb;
         wi.dest = mi.dest;
         wi.data = mi.rd ? mem_rdata : mi.alu;
         mi.wb = WB_EN_EXE; mi.rd = MEM_R_EN_EXE; mi.wr = MEM_W_EN_EXE;
         mi.dest = dest_EXE; mi.alu = alu_res_EXE; mi.st = st_val_EXE;
      end
   endtask

   task automatic check_all();
      bit acc;
      acc = mi.rd || mi.wr;
      chk("mem_req", mem_req, acc);
      chk("freeze", freeze, acc && !mem_ready);
      if (acc) begin
         chk("mem_we", mem_we, mi.wr);
         chk("mem_addr", mem_addr, mi.alu);
         if (mi.wr) chk("mem_wdata", mem_wdata, mi.st);
      end
      chk("dest_MEM", dest_MEM, mi.dest);
      chk("fwd_val_MEM", fwd_val_MEM, mi.alu);
      chk("WB_EN_MEM", WB_EN_MEM, FWD && mi.wb && !mi.rd);
      chk("ld_in_MEM", ld_in_MEM, mi.wb && mi.rd);
      chk("rf_we", rf_we, wi.wb);
      chk("WB_EN_WB", WB_EN_WB, FWD && wi.wb);
      if (wi.wb) begin
         chk("rf_waddr", rf_waddr, wi.dest);
         chk("rf_wdata", rf_wdata, wi.data);
         chk("dest_WB", dest_WB, wi.dest);
         chk("fwd_val_WB", fwd_val_WB, wi.data);
      end
   endtask

   task automatic neg();
      @(negedge clk);
      check_all();
      if (rf_we) wr_cnt++;
   endtask

   task automatic pos();
      @(posedge clk);
      if (rst) model_edge();
      #1;
   endtask

   task automatic set_exe(input bit wb, input bit rd, input bit wr,
                          input logic [AW-1:0] d, input logic [DW-1:0] a, input logic [DW-1:0] s);
      WB_EN_EXE = wb; MEM_R_EN_EXE = rd; MEM_W_EN_EXE = wr;
      dest_EXE = d; alu_res_EXE = a; st_val_EXE = s;
   endtask

   task automatic idle();
      set_exe(0, 0, 0, '0, '0, '0);
   endtask

   task automatic rand_exe();
      bit r;
      r = ($urandom_range(0, 3) == 0);
      set_exe($urandom_range(0, 1), r, !r && ($urandom_range(0, 3) == 0),
              AW'($urandom), $urandom, $urandom);
   endtask

   initial begin
      wr_cnt = 0;
      model_reset();
      rst = 1'b0;
      mem_ready = 1'b0; mem_rdata = '0;
      // reset held with random inputs: everything must read 0
      for (int i = 0; i < 4; i++) begin
         rand_exe();
         mem_ready = $urandom_range(0, 1); mem_rdata = $urandom;
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_all();
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_freeze", freeze, 1'b0);
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_fwd_val_MEM", fwd_val_MEM, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      // first edge loads the EXE values into MEM
      rand_exe(); mem_ready = 1'b1;
      neg(); pos();
      idle();
      for (int i = 0; i < 3; i++) begin neg(); pos(); end

      // ALU op: dest 5, result 0x1234
      mem_ready = 1'b0;
      set_exe(1, 0, 0, 5, 32'h1234, 32'h0);
      neg(); pos();
      idle();
      neg();
      chk("alu_dest_MEM", dest_MEM, 5);
      chk("alu_WB_EN_MEM", WB_EN_MEM, FWD);
      chk("alu_fwd_val_MEM", fwd_val_MEM, 32'h1234);
      pos();
      neg();
      chk("alu_rf_we", rf_we, 1'b1);
      chk("alu_rf_waddr", rf_waddr, 5);
      chk("alu_rf_wdata", rf_wdata, 32'h1234);
      chk("alu_WB_EN_WB", WB_EN_WB, FWD);
      pos();

      // Load: dest 7, addr 0x40, three not-ready cycles, then 0xBEEF
      wr_cnt = 0;
      set_exe(1, 1, 0, 7, 32'h40, 32'h0);
      neg(); pos();
      idle();
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("ld_freeze", freeze, 1'b1);
         chk("ld_in_MEM", ld_in_MEM, 1'b1);
         chk("ld_WB_EN_MEM", WB_EN_MEM, 1'b0);
         chk("ld_WB_EN_WB", WB_EN_WB, 1'b0);
         chk("ld_mem_addr", mem_addr, 32'h40);
         pos();
      end
      mem_ready = 1'b1; mem_rdata = 32'hBEEF;
      neg();
      chk("ld_freeze_done", freeze, 1'b0);
      pos();
      mem_ready = 1'b0; mem_rdata = 32'h0;
      neg();
      chk("ld_rf_we", rf_we, 1'b1);
      chk("ld_rf_waddr", rf_waddr, 7);
      chk("ld_rf_wdata", rf_wdata, 32'hBEEF);
      pos();
      neg(); pos();
      chk("ld_write_count", wr_cnt, 1);

      // Store: addr 0x80, data 0xAA, zero wait
      wr_cnt = 0;
      mem_ready = 1'b1;
      set_exe(0, 0, 1, 0, 32'h80, 32'hAA);
      neg(); pos();
      idle();
      neg();
      chk("st_mem_req", mem_req, 1'b1);
      chk("st_mem_we", mem_we, 1'b1);
      chk("st_mem_addr", mem_addr, 32'h80);
      chk("st_mem_wdata", mem_wdata, 32'hAA);
      chk("st_freeze", freeze, 1'b0);
      pos();
      neg();
      chk("st_mem_req_off", mem_req, 1'b0);
      pos();
      neg(); pos();
      chk("st_write_count", wr_cnt, 0);

      // Reset during the second WAIT cycle abandons the load
      wr_cnt = 0;
      mem_ready = 1'b0;
      set_exe(1, 1, 0, 9, 32'h44, 32'h0);
      neg(); pos();
      idle();
      neg(); pos();
      neg();
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      chk("rstw_mem_req", mem_req, 1'b0);
      chk("rstw_freeze", freeze, 1'b0);
      chk("rstw_rf_we", rf_we, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      mem_ready = 1'b1; mem_rdata = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin neg(); pos(); end
      chk("rstw_write_count", wr_cnt, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rand_exe();
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         neg(); pos();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
